fifo_write_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the cross-clock `fifo` among `REQUESTERS` independent producers. It sits on the `in_clock` side of the FIFO and drives `in_shift`/`in_data` from whichever requester holds the grant. It limits each grant to at most `BURST` words so that no producer can starve the others.

---
 rtl/fifo_write_arbiter.sv | 102 ++++++++++
 tb/tb_fifo_write_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among REQUESTERS producers,
// capping each grant at BURST words so no producer can starve the others.
//
// state | meaning
// IDLE  | no owner; scan req_valid from last+1 and grant the first hit
// GRANT | owner streams words to the FIFO until BURST words or valid drops
module fifo_write_arbiter #(
  parameter int WIDTH      = 16,
  parameter int REQUESTERS = 4,
  parameter int BURST      = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [REQUESTERS-1:0]       req_valid,
  input  logic [REQUESTERS*WIDTH-1:0] req_data,
  output logic [REQUESTERS-1:0]       req_ready,
  output logic [REQUESTERS-1:0]       grant,
  output logic                        busy,
  input  logic                        fifo_full,
  output logic                        fifo_shift,
  output logic [WIDTH-1:0]            fifo_data
);

  localparam int IDX_W = $clog2(REQUESTERS);
  localparam int CNT_W = $clog2(BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state;
  logic [IDX_W-1:0]      owner;
  logic [IDX_W-1:0]      last;
  logic [CNT_W-1:0]      count;
  logic [IDX_W-1:0]      pick;
  logic [REQUESTERS-1:0] pick_onehot;
  logic                  found;
  logic                  owner_valid;
  logic                  last_word;
  logic [WIDTH-1:0]      lane [REQUESTERS];

  for (genvar g = 0; g < REQUESTERS; g++) begin : g_lane
    assign lane[g] = req_data[g*WIDTH +: WIDTH];
  end

  // Cyclic scan starting just after the previous owner; last hit wins nothing,
  // the first valid index encountered is taken.
  always_comb begin
    int idx;
    idx         = 0;
    pick        = '0;
    pick_onehot = '0;
    found       = 1'b0;
    for (int i = 1; i <= REQUESTERS; i++) begin
      idx = (int'(last) + i) % REQUESTERS;
      if (!found && req_valid[idx]) begin
        found            = 1'b1;
        pick             = IDX_W'(idx);
        pick_onehot[idx] = 1'b1;
      end
    end
  end

  assign busy        = (state == GRANT);
  assign owner_valid = req_valid[owner];
  assign fifo_shift  = busy & owner_valid & ~fifo_full;
  assign req_ready   = fifo_full ? '0 : grant;
  assign fifo_data   = fifo_shift ? lane[owner] : '0;
  assign last_word   = fifo_shift && (count == CNT_W'(BURST - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= '0;
      last  <= IDX_W'(REQUESTERS - 1);
      count <= '0;
      grant <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= GRANT;
            owner <= pick;
            grant <= pick_onehot;
            count <= '0;
          end
        end
        GRANT: begin
          // A full FIFO with valid held simply stalls; there is no timeout.
          if (!owner_valid || last_word) begin
            state <= IDLE;
            last  <= owner;
            grant <= '0;
            count <= '0;
          end else if (fifo_shift) begin
            count <= count + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: a 4-requester BURST=4 instance and a
// 3-requester BURST=1 instance, checked against hand-computed grant/data traces.
module tb_fifo_write_arbiter;

  logic        clock;
  logic        reset_n;
  logic [3:0]  valid;
  logic [63:0] data;
  logic [3:0]  ready;
  logic [3:0]  grant;
  logic        busy;
  logic        full;
  logic        shift;
  logic [15:0] fdata;

  logic [2:0]  v1;
  logic [47:0] d1;
  logic [2:0]  r1;
  logic [2:0]  g1;
  logic        b1;
  logic        full1;
  logic        s1;
  logic [15:0] fd1;

  int n_vec;
  int n_bad;
  logic [15:0] fifo_q[$];

  fifo_write_arbiter #(.WIDTH(16), .REQUESTERS(4), .BURST(4)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(valid), .req_data(data),
    .req_ready(ready), .grant(grant), .busy(busy), .fifo_full(full),
    .fifo_shift(shift), .fifo_data(fdata)
  );

  fifo_write_arbiter #(.WIDTH(16), .REQUESTERS(3), .BURST(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req_valid(v1), .req_data(d1),
    .req_ready(r1), .grant(g1), .busy(b1), .fifo_full(full1),
    .fifo_shift(s1), .fifo_data(fd1)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (shift) fifo_q.push_back(fdata);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [15:0] w);
    data[i*16 +: 16] = w;
  endtask

  initial begin
    int kcnt [4];
    int slot;
    int pos;
    int k;
    logic [3:0]  exp_g;
    logic [15:0] exp_d;
    logic [15:0] exp_list [$];

    n_vec   = 0;
    n_bad   = 0;
    clock   = 1'b0;
    reset_n = 1'b0;
    full    = 1'b0;
    valid   = 4'hF;
    data    = '0;
    v1      = '0;
    d1      = '0;
    full1   = 1'b0;
    for (int i = 0; i < 4; i++) kcnt[i] = 0;

    // Reset state with every requester asking
    #2;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_shift", 32'(shift), 32'h0);
    check("rst_data", 32'(fdata), 32'h0);
    tick();
    tick();
    check("rst_grant_clk", 32'(grant), 32'h0);
    check("rst_shift_clk", 32'(shift), 32'h0);

    // Round robin, all valid, BURST=4: 4 words then 1 idle cycle per grant
    for (int i = 0; i < 4; i++) set_lane(i, {4'(i), 12'(kcnt[i])});
    reset_n = 1'b1;
    tick();
    for (int c = 0; c < 25; c++) begin
      slot  = c / 5;
      pos   = c % 5;
      valid = (c < 24) ? 4'hF : 4'h0;
      for (int i = 0; i < 4; i++) set_lane(i, {4'(i), 12'(kcnt[i])});
      #1;
      exp_g = (pos < 4) ? 4'(1 << (slot % 4)) : 4'h0;
      check("rr_grant", 32'(grant), 32'(exp_g));
      check("rr_busy", 32'(busy), (pos < 4) ? 32'h1 : 32'h0);
      check("rr_shift", 32'(shift), (pos < 4) ? 32'h1 : 32'h0);
      if (pos < 4) begin
        exp_d = {4'(slot % 4), 12'(pos + 4 * (slot / 4))};
        check("rr_data", 32'(fdata), 32'(exp_d));
        exp_list.push_back(exp_d);
        kcnt[slot % 4]++;
      end
      tick();
    end
    check("rr_fifo_count", 32'(fifo_q.size()), 32'd20);
    for (int n = 0; n < 20 && n < fifo_q.size(); n++)
      check("rr_fifo_order", 32'(fifo_q[n]), 32'(exp_list[n]));
    fifo_q.delete();
    exp_list.delete();

    // Early release: requester 2 sends 2 words then drops valid
    valid = 4'b0100;
    set_lane(2, 16'hA200);
    #1;
    check("er_idle", 32'(grant), 32'h0);
    tick();
    #1;
    check("er_grant0", 32'(grant), 32'h4);
    check("er_data0", 32'(fdata), 32'hA200);
    tick();
    set_lane(2, 16'hA201);
    #1;
    check("er_grant1", 32'(grant), 32'h4);
    check("er_data1", 32'(fdata), 32'hA201);
    tick();
    valid = 4'b0000;
    #1;
    check("er_grant2", 32'(grant), 32'h4);
    check("er_shift2", 32'(shift), 32'h0);
    check("er_ready2", 32'(ready), 32'h4);
    tick();
    // Requester 1 after last=2: scan wraps through 3 and 0
    valid = 4'b0010;
    set_lane(1, 16'hB100);
    #1;
    check("er_released", 32'(busy), 32'h0);
    tick();
    #1;
    check("skip_grant", 32'(grant), 32'h2);
    check("skip_data", 32'(fdata), 32'hB100);
    tick();
    valid = 4'b0000;
    tick();
    tick();
    check("skip_idle", 32'(busy), 32'h0);
    check("er_fifo_count", 32'(fifo_q.size()), 32'd3);
    if (fifo_q.size() == 3) begin
      check("er_fifo0", 32'(fifo_q[0]), 32'hA200);
      check("er_fifo1", 32'(fifo_q[1]), 32'hA201);
      check("er_fifo2", 32'(fifo_q[2]), 32'hB100);
    end
    fifo_q.delete();

    // Stall on full: 2 words, 5 full cycles, then the remaining 2 words
    valid = 4'b1000;
    k = 0;
    set_lane(3, 16'hC300);
    tick();
    for (int c = 0; c < 10; c++) begin
      full = (c >= 2 && c <= 6);
      if (c == 9) valid = 4'b0000;
      set_lane(3, 16'(16'hC300 + k));
      #1;
      if (full) begin
        check("st_shift", 32'(shift), 32'h0);
        check("st_ready", 32'(ready), 32'h0);
        check("st_grant", 32'(grant), 32'h8);
      end else if (c < 9) begin
        check("st_xfer_shift", 32'(shift), 32'h1);
        check("st_xfer_data", 32'(fdata), 32'(16'hC300 + k));
        k++;
      end else begin
        check("st_release", 32'(grant), 32'h0);
        check("st_release_busy", 32'(busy), 32'h0);
      end
      tick();
    end
    full = 1'b0;
    check("st_fifo_count", 32'(fifo_q.size()), 32'd4);
    for (int n = 0; n < 4 && n < fifo_q.size(); n++)
      check("st_fifo_word", 32'(fifo_q[n]), 32'(16'hC300 + n));
    fifo_q.delete();

    // Async reset after 3 words of a burst
    valid = 4'b0100;
    set_lane(2, 16'hE200);
    tick();
    for (int c = 0; c < 3; c++) begin
      set_lane(2, 16'(16'hE200 + c));
      #1;
      check("ar_shift", 32'(shift), 32'h1);
      tick();
    end
    set_lane(2, 16'hE203);
    #1;
    check("ar_pending", 32'(shift), 32'h1);
    #1;
    reset_n = 1'b0;
    #1;
    check("ar_shift_drop", 32'(shift), 32'h0);
    check("ar_grant_drop", 32'(grant), 32'h0);
    check("ar_busy_drop", 32'(busy), 32'h0);
    check("ar_data_drop", 32'(fdata), 32'h0);
    tick();
    check("ar_fifo_count", 32'(fifo_q.size()), 32'd3);
    for (int n = 0; n < 3 && n < fifo_q.size(); n++)
      check("ar_fifo_word", 32'(fifo_q[n]), 32'(16'hE200 + n));
    fifo_q.delete();
    valid   = 4'b0101;
    reset_n = 1'b1;
    tick();
    check("ar_restart", 32'(grant), 32'h1);
    valid = 4'b0000;
    tick();
    tick();

    // BURST=1 with 3 requesters: 0, 1, 2 alternating with idle cycles
    v1 = 3'b111;
    d1 = {16'h0D02, 16'h0D01, 16'h0D00};
    tick();
    for (int c = 0; c < 6; c++) begin
      slot = c / 2;
      pos  = c % 2;
      #1;
      check("b1_grant", 32'(g1), (pos == 0) ? 32'(1 << slot) : 32'h0);
      check("b1_shift", 32'(s1), (pos == 0) ? 32'h1 : 32'h0);
      if (pos == 0) check("b1_data", 32'(fd1), 32'(16'h0D00 + slot));
      tick();
    end
    v1 = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
